// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants and FSM state type for the sorted-vector streamer
package sort_pkg;

    localparam int SORT_N     = 8;
    localparam int SORT_W     = 8;
    localparam int SORT_IDX_W = $clog2(SORT_N);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/sort_order_chk.sv
// rtl/sort_order_chk.sv - sticky flag raised when a streamed element is smaller than its predecessor
module sort_order_chk #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         beat,
    input  logic         first,
    input  logic [W-1:0] data,
    output logic         err
);

    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= '0;
            err  <= 1'b0;
        end else begin
            if (clear) begin
                err <= 1'b0;
            end else if (beat && !first && (data < prev)) begin
                err <= 1'b1;
            end
            // Only accepted beats advance the reference; stalled cycles must not.
            if (beat) begin
                prev <= data;
            end
        end
    end

endmodule

// File: rtl/sorted_stream_out.sv
// rtl/sorted_stream_out.sv - captures a packed sorted vector and streams it lane 0 first
// Optional order checking enabled with macro SORT_CHECK_EN.
module sorted_stream_out
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [N*W-1:0]        sorted_in,
    output logic                  busy,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(N)-1:0]  out_idx,
    output logic                  out_last,
    output logic                  sort_err
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t         state;
    state_t         state_nxt;
    logic [N*W-1:0] cap;
    logic [IW-1:0]  idx;
    logic [W-1:0]   lanes [N];
    logic           load_ok;
    logic           beat;
    logic           at_last;

    assign load_ok = (state == IDLE) && load;
    assign beat    = out_valid && out_ready;
    assign at_last = (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = STREAM;
            STREAM:  if (beat && at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture is gated by IDLE so sorted_in may change freely during a stream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap <= '0;
            idx <= '0;
        end else if (load_ok) begin
            cap <= sorted_in;
            idx <= '0;
        end else if (beat && !at_last) begin
            idx <= idx + 1'b1;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign lanes[k] = cap[k*W +: W];
    end

    assign out_valid = (state == STREAM);
    assign busy      = out_valid;
    assign out_idx   = idx;
    assign out_data  = lanes[idx];
    assign out_last  = out_valid && at_last;

`ifdef SORT_CHECK_EN
    sort_order_chk #(
        .W (W)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .clear (load_ok),
        .beat  (beat),
        .first (idx == '0),
        .data  (out_data),
        .err   (sort_err)
    );
`else
    assign sort_err = 1'b0;
`endif

endmodule
